// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: widths, NOP encoding and PC helpers shared by fetch and decode.
package fetch_unit_pkg;
    localparam int INST_WIDTH = 32;
    localparam int PC_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [PC_WIDTH-1:0] PC_STEP = 32'd4;

    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return pc & ~PC_WIDTH'(3);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry FIFO with flush; head is read straight from storage.
module fetch_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       count_q, count_d;

    always_comb count_d = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push && !flush) mem_q[wr_ptr_q] <= din;
            wr_ptr_q <= flush ? 1'b0 : wr_ptr_q ^ push;
            rd_ptr_q <= flush ? 1'b0 : rd_ptr_q ^ pop;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch from an external text ROM into a
// 2-entry buffer, with redirect flush and one instruction per cycle.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 10,
    parameter int                  DATA_WIDTH = INST_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [PC_WIDTH-1:0]   out_pc
);
    localparam int EW = PC_WIDTH + DATA_WIDTH;

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]          count;
    logic [EW-1:0]       head;
    logic                take, push, pop;

    assign out_valid = count != 2'd0;
    assign take      = out_valid && out_ready;
    // A redirect discards whatever decode takes in the same cycle.
    assign pop       = take && !redirect_valid;
    assign push      = !redirect_valid && (count != 2'd2 || take);

    always_comb fetch_pc_d = redirect_valid ? align_pc(redirect_pc) : push ? fetch_pc_q + PC_STEP : fetch_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_pc_q <= RESET_PC;
        else     fetch_pc_q <= fetch_pc_d;
    end

    assign rom_addr = fetch_pc_q[ADDR_WIDTH+1:2];

    fetch_fifo #(.WIDTH(EW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({fetch_pc_q, rom_data}),
        .dout  (head),
        .count (count)
    );

    assign out_pc   = out_valid ? head[EW-1:DATA_WIDTH] : '0;
    assign out_inst = out_valid ? head[DATA_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; expected {pc,inst} entries are queued as the
// model fetches and compared against the head presented by the DUT.
module tb_fetch_unit;
    localparam int AW = 10;
    localparam logic [31:0] RST_PC = 32'h0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_inst, out_pc;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_pc = RST_PC;

    always #5 clk = ~clk;

    assign rom_data = 32'h1000_0000 + {22'd0, rom_addr};

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'h1000_0000 + {22'd0, pc[11:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge: drive, check the pre-edge state, advance the model.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [63:0] head;
        out_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rpc;
        #1;
        head = exp_q.size() != 0 ? exp_q[0] : 64'd0;
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("rom_addr", 32'(rom_addr), 32'(m_pc[AW+1:2]));
        chk("out_pc", out_pc, head[63:32]);
        chk("out_inst", out_inst, head[31:0]);
        if (rv) begin
            exp_q.delete();
            m_pc = rpc & ~32'd3;
        end else begin
            if (rdy && exp_q.size() != 0) head = exp_q.pop_front();
            if (exp_q.size() < 2) begin
                exp_q.push_back({m_pc, rom_word(m_pc)});
                m_pc += 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'(RST_PC[AW+1:2]));
        exp_q.delete();
        m_pc = RST_PC;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("init_valid", 32'(out_valid), 32'd0);
        chk("init_addr", 32'(rom_addr), 32'(RST_PC[AW+1:2]));
        chk("init_pc", out_pc, 32'd0);
        chk("init_inst", out_inst, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) cycle(1'b1, 1'b0, 32'h0);
        async_reset();
        cycle(1'b1, 1'b0, 32'h0);
        repeat (5) cycle(1'b0, 1'b0, 32'h0);
        chk("hold_pc", out_pc, 32'h0);
        chk("hold_addr", 32'(rom_addr), 32'd2);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0103);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("redir_pc", out_pc, 32'h100);
        chk("redir_inst", out_inst, 32'h1000_0040);
        repeat (3) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0FFC);
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        async_reset();
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        repeat (600) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
